// File: rtl/serializador_10b_pkg.sv
// Shared types and constants for the 10-bit serializer and its companion decoder.
package serializador_pkg;
  localparam int ANCHO = 10;

  typedef enum logic [1:0] {
    ESPERA  = 2'd0,
    DATOS   = 2'd1,
    RELLENO = 2'd2
  } estado_t;

  // K28.5 in both polarities, bit 9 = a
  localparam logic [ANCHO-1:0] K285_RDN = 10'b0011111010;
  localparam logic [ANCHO-1:0] K285_RDP = 10'b1100000101;
endpackage

// File: rtl/serializador_10b_if.sv
// Word handshake from the 8b/10b encoder into the serializer.
interface serializador_10b_if;
  logic [serializador_pkg::ANCHO-1:0] datos;
  logic                               valido;
  logic                               listo;

  modport master (output datos, output valido, input listo);
  modport slave  (input datos, input valido, output listo);
endinterface

// File: rtl/serializador_10b_contador_unos.sv
// Combinational popcount of a 10-bit code group.
module contador_unos_10 (
  input  logic [9:0] w,
  output logic [3:0] n
);
  always_comb begin
    n = 4'd0;
    for (int i = 0; i < 10; i++) n = n + 4'(w[i]);
  end
endmodule

// File: rtl/serializador_10b.sv
// 10-bit serializer, MSB first, with K28.5 idle fill and running-disparity check.
module serializador_10b
  import serializador_pkg::*;
#(
  parameter logic [ANCHO-1:0] COMA_RDN   = K285_RDN,
  parameter logic [ANCHO-1:0] COMA_RDP   = K285_RDP,
  parameter logic             RD_INICIAL = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enb,
  serializador_10b_if.slave   bus,
  output logic                serial,
  output logic                frontera,
  output logic                relleno,
  output logic                rd,
  output logic                err_disp
);
  localparam logic [3:0] CNT_FIN = 4'd9;

  estado_t          estado, estado_n;
  logic [ANCHO-1:0] shreg, shreg_n, palabra;
  logic [3:0]       cnt, cnt_n, n_unos;
  logic             rd_q, rd_n, err_q, err_n;

  // Idle slots carry the comma that flips the current disparity
  assign palabra = bus.valido ? bus.datos : (rd_q ? COMA_RDP : COMA_RDN);

  contador_unos_10 u_unos (.w(palabra), .n(n_unos));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estado <= ESPERA;
      shreg  <= '0;
      cnt    <= CNT_FIN;
      rd_q   <= RD_INICIAL;
      err_q  <= 1'b0;
    end else begin
      estado <= estado_n;
      shreg  <= shreg_n;
      cnt    <= cnt_n;
      rd_q   <= rd_n;
      err_q  <= err_n;
    end
  end

  always_comb begin
    estado_n = estado;
    shreg_n  = shreg;
    cnt_n    = cnt;
    rd_n     = rd_q;
    err_n    = 1'b0;
    if (cnt == CNT_FIN) begin
      if (enb) begin
        shreg_n  = palabra;
        cnt_n    = 4'd0;
        estado_n = bus.valido ? DATOS : RELLENO;
        err_n    = (n_unos < 4'd4) || (n_unos > 4'd6) ||
                   (!rd_q && n_unos == 4'd4) || (rd_q && n_unos == 4'd6);
        // Disparity resyncs on the loaded word even when it is illegal
        if (n_unos > 4'd5)      rd_n = 1'b1;
        else if (n_unos < 4'd5) rd_n = 1'b0;
      end else begin
        shreg_n  = '0;
        estado_n = ESPERA;
      end
    end else begin
      shreg_n = {shreg[ANCHO-2:0], 1'b0};
      cnt_n   = cnt + 4'd1;
    end
  end

  assign bus.listo = enb && (cnt == CNT_FIN);
  assign serial    = shreg[ANCHO-1];
  assign frontera  = (estado != ESPERA) && (cnt == 4'd0);
  assign relleno   = (estado == RELLENO);
  assign rd        = rd_q;
  assign err_disp  = err_q;
endmodule

// File: tb/tb_serializador_10b.sv
// Scoreboard bench for serializador_10b: expected bit slots queued on drive, popped per clk.
module tb_serializador_10b;
  typedef struct packed {
    logic serial;
    logic frontera;
    logic relleno;
    logic rd;
    logic err;
    logic listo;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enb = 1'b0;
  logic serial, frontera, relleno, rd, err_disp;

  serializador_10b_if bus ();

  serializador_10b dut (
    .clk      (clk),
    .rst      (rst),
    .enb      (enb),
    .bus      (bus),
    .serial   (serial),
    .frontera (frontera),
    .relleno  (relleno),
    .rd       (rd),
    .err_disp (err_disp)
  );

  always #5 clk = ~clk;

  obs_t q[$];
  obs_t exp_o, obs_o;
  logic mrd = 1'b0;
  int   vectors = 0;
  int   errors  = 0;

  localparam logic [9:0] K_RDN = 10'b0011111010;
  localparam logic [9:0] K_RDP = 10'b1100000101;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int unos(input logic [9:0] w);
    int c = 0;
    for (int i = 0; i < 10; i++) if (w[i]) c++;
    return c;
  endfunction

  function automatic obs_t sample();
    return '{serial, frontera, relleno, rd, err_disp, bus.listo};
  endfunction

  // Queue the 10 expected bit slots of one word and advance the disparity model
  task automatic push_word(input logic [9:0] w_in, input logic fill, input logic listo_end);
    logic [9:0] w;
    int n;
    logic e;
    w = fill ? (mrd ? K_RDP : K_RDN) : w_in;
    n = unos(w);
    e = (n < 4) || (n > 6) || (!mrd && n == 4) || (mrd && n == 6);
    if (n > 5) mrd = 1'b1;
    else if (n < 5) mrd = 1'b0;
    for (int i = 0; i < 10; i++)
      q.push_back('{w[9-i], i == 0, fill, mrd, (i == 0) ? e : 1'b0, (i == 9) ? listo_end : 1'b0});
  endtask

  task automatic test_reset();
    bus.valido = 1'b0;
    bus.datos  = '0;
    tick();
    obs_o = sample();
    vectors++;
    if (obs_o !== obs_t'(6'b000000)) begin
      errors++; $display("FAIL reset_idle obs=%b exp=%b", obs_o, 6'b000000);
    end
    enb = 1'b1;
    #1;
    vectors++;
    if (bus.listo !== 1'b1) begin errors++; $display("FAIL reset_listo obs=%b exp=1", bus.listo); end
    rst = 1'b1;
    bus.valido = 1'b1;
    bus.datos  = K_RDN;
    tick();
    bus.valido = 1'b0;
    repeat (4) tick();
    vectors++;
    if ({serial, rd} !== 2'b11) begin errors++; $display("FAIL pre_reset_cnt4 obs=%b exp=11", {serial, rd}); end
    #2 rst = 1'b0;
    #1;
    obs_o = sample();
    vectors++;
    if (obs_o !== obs_t'(6'b000001)) begin
      errors++; $display("FAIL reset_midword obs=%b exp=%b", obs_o, 6'b000001);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.listo !== 1'b1) begin errors++; $display("FAIL release_listo obs=%b exp=1", bus.listo); end
    mrd = 1'b0;
  endtask

  task automatic test_data();
    bus.valido = 1'b1;
    bus.datos  = 10'b0011111010;
    push_word(10'b0011111010, 1'b0, 1'b1);
    tick();
    bus.valido = 1'b0;
    for (int i = 0; q.size() > 0; i++) begin
      exp_o = q.pop_front();
      obs_o = sample();
      vectors++;
      if (obs_o !== exp_o) begin errors++; $display("FAIL data[%0d] obs=%b exp=%b", i, obs_o, exp_o); end
      if (q.size() > 0) tick();
    end
  endtask

  task automatic test_idle();
    bus.valido = 1'b0;
    push_word('0, 1'b1, 1'b1);
    push_word('0, 1'b1, 1'b1);
    tick();
    for (int i = 0; q.size() > 0; i++) begin
      exp_o = q.pop_front();
      obs_o = sample();
      vectors++;
      if (obs_o !== exp_o) begin errors++; $display("FAIL idle[%0d] obs=%b exp=%b", i, obs_o, exp_o); end
      if (q.size() > 0) tick();
    end
  endtask

  task automatic test_disp();
    bus.valido = 1'b0;
    push_word('0, 1'b1, 1'b1);
    push_word(10'b0100011100, 1'b0, 1'b1);
    push_word(10'b1111111000, 1'b0, 1'b1);
    tick();
    for (int i = 0; q.size() > 0; i++) begin
      exp_o = q.pop_front();
      obs_o = sample();
      vectors++;
      if (obs_o !== exp_o) begin errors++; $display("FAIL disp[%0d] obs=%b exp=%b", i, obs_o, exp_o); end
      if (i == 9)  begin bus.valido = 1'b1; bus.datos = 10'b0100011100; end
      if (i == 19) bus.datos = 10'b1111111000;
      if (i == 20) bus.valido = 1'b0;
      if (q.size() > 0) tick();
    end
  endtask

  task automatic test_enb_drop();
    bus.valido = 1'b1;
    bus.datos  = 10'b1010101010;
    push_word(10'b1010101010, 1'b0, 1'b0);
    tick();
    bus.valido = 1'b0;
    for (int i = 0; q.size() > 0; i++) begin
      exp_o = q.pop_front();
      obs_o = sample();
      vectors++;
      if (obs_o !== exp_o) begin errors++; $display("FAIL drop[%0d] obs=%b exp=%b", i, obs_o, exp_o); end
      if (i == 3) enb = 1'b0;
      if (q.size() > 0) tick();
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      obs_o = sample();
      vectors++;
      if (obs_o !== obs_t'({5'b00000, 1'b0} | {3'b000, mrd, 2'b00})) begin
        errors++; $display("FAIL drop_idle[%0d] obs=%b exp=%b", k, obs_o, {3'b000, mrd, 2'b00});
      end
    end
    enb = 1'b1;
    #1;
    vectors++;
    if (bus.listo !== 1'b1) begin errors++; $display("FAIL reenb_listo obs=%b exp=1", bus.listo); end
    bus.valido = 1'b1;
    bus.datos  = 10'b1100110010;
    push_word(10'b1100110010, 1'b0, 1'b1);
    tick();
    bus.valido = 1'b0;
    for (int i = 0; q.size() > 0; i++) begin
      exp_o = q.pop_front();
      obs_o = sample();
      vectors++;
      if (obs_o !== exp_o) begin errors++; $display("FAIL reenb[%0d] obs=%b exp=%b", i, obs_o, exp_o); end
      if (q.size() > 0) tick();
    end
  endtask

  task automatic test_back_to_back();
    bus.valido = 1'b0;
    push_word('0, 1'b1, 1'b1);
    push_word(10'b1001110100, 1'b0, 1'b1);
    push_word('0, 1'b1, 1'b1);
    tick();
    for (int k = 0; q.size() > 0; k++) begin
      exp_o = q.pop_front();
      obs_o = sample();
      vectors++;
      if (obs_o !== exp_o) begin errors++; $display("FAIL bp[%0d] obs=%b exp=%b", k, obs_o, exp_o); end
      if (k == 2)  begin bus.valido = 1'b1; bus.datos = 10'b1001110100; end
      if (k == 10) bus.valido = 1'b0;
      if (q.size() > 0) tick();
    end
  endtask

  initial begin
    test_reset();
    test_data();
    test_idle();
    test_disp();
    test_enb_drop();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
